// File: rtl/pattern_ctrl_if.sv
// Host/OSD pattern request channel into the pattern controller.
// Valid/ready: a request transfers when cmd_valid and cmd_ready are both high.
interface pattern_ctrl_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [7:0] cmd_pattern;

   modport master (
      output cmd_valid,
      output cmd_pattern,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid,
      input  cmd_pattern,
      output cmd_ready
   );
endinterface

// File: rtl/pattern_ctrl.sv
// Test-pattern sequencing controller: measures active picture size, derives
// the ramp increment with a restoring divider, and switches patterns on frame boundaries.
module pattern_ctrl #(
   parameter int B               = 8,
   parameter int X_BITS          = 13,
   parameter int Y_BITS          = 13,
   parameter int FRACTIONAL_BITS = 12,
   parameter int RESET_PATTERN   = 5
) (
   input  logic                         clk_in,
   input  logic                         reset,
   input  logic                         vn_in,
   input  logic                         dn_in,
   pattern_ctrl_if.slave                cmd,
   input  logic                         auto_en,
   input  logic [7:0]                   frames_per_pattern,
   input  logic [7:0]                   num_patterns,
   output logic [7:0]                   pattern,
   output logic [B+FRACTIONAL_BITS-1:0] ramp_step,
   output logic [X_BITS-1:0]            total_active_pix,
   output logic [Y_BITS-1:0]            total_active_lines,
   output logic                         params_valid,
   output logic                         frame_start
);

   localparam int QW = B + FRACTIONAL_BITS;
   localparam int CW = $clog2(QW + 1);

   typedef enum logic [1:0] {
      IDLE,
      DIV,
      DONE
   } div_st_e;

   logic              vn_q, dn_q;
   logic [X_BITS-1:0] pix_cnt_q, line_len_q, tpix_q;
   logic [Y_BITS-1:0] line_cnt_q, tlines_q;
   logic              fs_q;
   logic              fb, dn_fall, div_start;

   div_st_e           state_q, state_d;
   logic [X_BITS-1:0] rem_q, rem_d;
   logic [X_BITS:0]   rem_sh;
   logic [QW-1:0]     quo_q, quo_d, ramp_q, ramp_d;
   logic [CW-1:0]     bcnt_q, bcnt_d;
   logic              pv_q, pv_d;

   logic              pend_q;
   logic [7:0]        pend_pat_q, pat_q, frm_q;
   logic [8:0]        frm_inc, pat_inc, fpp_eff, np_eff;

   assign fb        = vn_q & ~vn_in;
   assign dn_fall   = dn_q & ~dn_in;
   assign div_start = fb && (line_len_q != tpix_q);

   always_ff @(posedge clk_in) begin
      if (reset) begin
         vn_q       <= 1'b0;
         dn_q       <= 1'b0;
         pix_cnt_q  <= '0;
         line_len_q <= '0;
         line_cnt_q <= '0;
         tlines_q   <= '0;
         tpix_q     <= '0;
         fs_q       <= 1'b0;
      end else begin
         vn_q <= vn_in;
         dn_q <= dn_in;
         fs_q <= fb;
         if (dn_in) begin
            if (pix_cnt_q != '1)
               pix_cnt_q <= pix_cnt_q + 1'b1;
         end else if (dn_fall) begin
            pix_cnt_q <= '0;
         end
         // line_len restarts each frame so a frame with no active lines reads 0
         if (fb) begin
            tlines_q   <= line_cnt_q;
            line_cnt_q <= '0;
            line_len_q <= '0;
         end else if (dn_fall) begin
            line_len_q <= pix_cnt_q;
            if (line_cnt_q != '1)
               line_cnt_q <= line_cnt_q + 1'b1;
         end
         if (div_start)
            tpix_q <= line_len_q;
      end
   end

   // Dividend is 2^QW; its leading 1 is preloaded as the first remainder.
   assign rem_sh = {rem_q, 1'b0};

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      bcnt_d  = bcnt_q;
      ramp_d  = ramp_q;
      pv_d    = pv_q;
      unique case (state_q)
         IDLE: ;
         DIV: begin
            if (rem_sh >= {1'b0, tpix_q}) begin
               rem_d = rem_sh[X_BITS-1:0] - tpix_q;
               quo_d = {quo_q[QW-2:0], 1'b1};
            end else begin
               rem_d = rem_sh[X_BITS-1:0];
               quo_d = {quo_q[QW-2:0], 1'b0};
            end
            bcnt_d = bcnt_q + 1'b1;
            if (bcnt_q == CW'(QW - 1))
               state_d = DONE;
         end
         DONE: begin
            ramp_d  = quo_q;
            pv_d    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (div_start) begin
         if (line_len_q == '0) begin
            ramp_d  = '0;
            pv_d    = 1'b1;
            state_d = IDLE;
         end else begin
            state_d = DIV;
            rem_d   = X_BITS'(1);
            quo_d   = '0;
            bcnt_d  = '0;
            pv_d    = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (reset) begin
         state_q <= IDLE;
         rem_q   <= '0;
         quo_q   <= '0;
         bcnt_q  <= '0;
         ramp_q  <= '0;
         pv_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         bcnt_q  <= bcnt_d;
         ramp_q  <= ramp_d;
         pv_q    <= pv_d;
      end
   end

   assign frm_inc = {1'b0, frm_q} + 9'd1;
   assign pat_inc = {1'b0, pat_q} + 9'd1;
   assign fpp_eff = (frames_per_pattern == 8'd0) ? 9'd1 : {1'b0, frames_per_pattern};
   assign np_eff  = (num_patterns == 8'd0) ? 9'd1 : {1'b0, num_patterns};

   assign cmd.cmd_ready = ~pend_q;

   always_ff @(posedge clk_in) begin
      if (reset) begin
         pat_q      <= 8'(RESET_PATTERN);
         pend_q     <= 1'b0;
         pend_pat_q <= '0;
         frm_q      <= '0;
      end else begin
         if (fb) begin
            if (pend_q) begin
               pat_q  <= pend_pat_q;
               pend_q <= 1'b0;
               frm_q  <= '0;
            end else if (auto_en) begin
               if (frm_inc >= fpp_eff) begin
                  frm_q <= '0;
                  pat_q <= (pat_inc < np_eff) ? pat_inc[7:0] : 8'd0;
               end else begin
                  frm_q <= frm_inc[7:0];
               end
            end else begin
               frm_q <= '0;
            end
         end else if (!auto_en) begin
            frm_q <= '0;
         end
         // a request landing on a boundary waits for the following one
         if (cmd.cmd_valid && !pend_q) begin
            pend_q     <= 1'b1;
            pend_pat_q <= cmd.cmd_pattern;
         end
      end
   end

   assign pattern            = pat_q;
   assign ramp_step          = ramp_q;
   assign total_active_pix   = tpix_q;
   assign total_active_lines = tlines_q;
   assign params_valid       = pv_q;
   assign frame_start        = fs_q;

endmodule

// File: tb/tb_pattern_ctrl.sv
// Randomized scoreboard bench for pattern_ctrl: a frame-level reference model
// queues expectations that a monitor checks on frame_start and params_valid.
module tb_pattern_ctrl;
   localparam int QW = 20;

   typedef struct {
      int pat;
      int tpix;
      int tl;
      int ramp;
      int pv;
   } fexp_t;

   logic          clk_in = 1'b0;
   logic          reset = 1'b1;
   logic          vn_in = 1'b1;
   logic          dn_in = 1'b0;
   logic          auto_en = 1'b0;
   logic [7:0]    fpp = 8'd1;
   logic [7:0]    np = 8'd1;
   logic [7:0]    pattern;
   logic [QW-1:0] ramp_step;
   logic [12:0]   tap;
   logic [12:0]   tal;
   logic          pv;
   logic          fs;

   pattern_ctrl_if cif ();

   pattern_ctrl dut (
      .clk_in             (clk_in),
      .reset              (reset),
      .vn_in              (vn_in),
      .dn_in              (dn_in),
      .cmd                (cif),
      .auto_en            (auto_en),
      .frames_per_pattern (fpp),
      .num_patterns       (np),
      .pattern            (pattern),
      .ramp_step          (ramp_step),
      .total_active_pix   (tap),
      .total_active_lines (tal),
      .params_valid       (pv),
      .frame_start        (fs)
   );

   always #5 clk_in = ~clk_in;

   int    n_cmp = 0;
   int    n_bad = 0;
   fexp_t fq[$];
   int    rq[$];

   // frame-level reference state
   int m_pat = 5;
   bit m_pend = 0;
   int m_pp = 0;
   int m_frm = 0;
   int m_tpix = 0;
   int m_ramp = 0;
   bit m_pv = 0;
   bit m_out = 0;
   int m_oval = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
      end
   endtask

   task automatic model_fb(input int nl, input int ll, input bit short_f);
      fexp_t e;
      int    q;
      int    fe;
      int    ne;
      if (m_out) begin
         if (short_f) void'(rq.pop_back());
         else begin
            m_ramp = m_oval;
            m_pv   = 1;
         end
         m_out = 0;
      end
      if (ll != m_tpix) begin
         m_tpix = ll;
         if (ll == 0) begin
            m_ramp = 0;
            m_pv   = 1;
         end else begin
            q = (1 << QW) / ll;
            if (q > (1 << QW) - 1) q = (1 << QW) - 1;
            m_oval = q;
            m_out  = 1;
            m_pv   = 0;
            rq.push_back(q);
         end
      end
      fe = (int'(fpp) == 0) ? 1 : int'(fpp);
      ne = (int'(np) == 0) ? 1 : int'(np);
      if (m_pend) begin
         m_pat  = m_pp;
         m_pend = 0;
         m_frm  = 0;
      end else if (auto_en) begin
         m_frm++;
         if (m_frm >= fe) begin
            m_frm = 0;
            m_pat = (m_pat + 1 < ne) ? m_pat + 1 : 0;
         end
      end else begin
         m_frm = 0;
      end
      e.pat  = m_pat;
      e.tpix = m_tpix;
      e.tl   = nl;
      e.ramp = m_ramp;
      e.pv   = int'(m_pv);
      fq.push_back(e);
   endtask

   task automatic model_reset();
      if (m_out) void'(rq.pop_back());
      m_out  = 0;
      m_pat  = 5;
      m_pend = 0;
      m_frm  = 0;
      m_tpix = 0;
      m_ramp = 0;
      m_pv   = 0;
   endtask

   // called at a negedge with vn_in high; returns at a negedge with vn_in high
   task automatic frame(input int nl, input int px, input bit short_f, input int cmd_fb);
      int last;
      int p;
      bit acc;
      last = 0;
      for (int i = 0; i < nl; i++) begin
         p = (px > 0) ? px : int'($urandom_range(1, 40));
         dn_in = 1'b1;
         repeat (p) @(negedge clk_in);
         dn_in = 1'b0;
         repeat (3) @(negedge clk_in);
         last = p;
      end
      repeat (short_f ? 1 : 30) @(negedge clk_in);
      vn_in = 1'b0;
      acc = !m_pend;
      if (cmd_fb >= 0) begin
         cif.cmd_valid   = 1'b1;
         cif.cmd_pattern = 8'(cmd_fb);
         chk("ready_at_fb", 32'(cif.cmd_ready), 32'(acc));
      end
      model_fb(nl, last, short_f);
      if (cmd_fb >= 0 && acc) begin
         m_pend = 1;
         m_pp   = cmd_fb;
      end
      @(negedge clk_in);
      cif.cmd_valid = 1'b0;
      repeat (2) @(negedge clk_in);
      vn_in = 1'b1;
      repeat (2) @(negedge clk_in);
   endtask

   task automatic send_cmd(input int p);
      bit acc;
      acc = !m_pend;
      cif.cmd_valid   = 1'b1;
      cif.cmd_pattern = 8'(p);
      chk("cmd_ready", 32'(cif.cmd_ready), 32'(acc));
      @(negedge clk_in);
      cif.cmd_valid = 1'b0;
      if (acc) begin
         m_pend = 1;
         m_pp   = p;
      end
      chk("ready_after_cmd", 32'(cif.cmd_ready), 32'(!m_pend));
      chk("pattern_hold", 32'(pattern), 32'(m_pat));
   endtask

   // monitor: frame_start pops a frame expectation, a params_valid rise pops a quotient
   int   cyc = 0;
   int   fs_cyc = 0;
   logic pv_prev = 1'b0;

   initial begin
      fexp_t e;
      int    r;
      forever begin
         @(negedge clk_in);
         cyc++;
         if (fs === 1'b1) begin
            if (fq.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL frame_start: got pulse, required none");
            end else begin
               e = fq.pop_front();
               chk("pattern", 32'(pattern), 32'(e.pat));
               chk("total_active_pix", 32'(tap), 32'(e.tpix));
               chk("total_active_lines", 32'(tal), 32'(e.tl));
               chk("ramp_at_fs", 32'(ramp_step), 32'(e.ramp));
               chk("pv_at_fs", 32'(pv), 32'(e.pv));
            end
            fs_cyc = cyc;
         end else if (pv === 1'b1 && pv_prev === 1'b0) begin
            if (rq.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL params_valid: got rise with ramp 0x%0h, required none", ramp_step);
            end else begin
               r = rq.pop_front();
               chk("ramp_step", 32'(ramp_step), 32'(r));
               chk("ramp_latency", 32'(cyc - fs_cyc), 32'd21);
            end
         end
         pv_prev = pv;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got no finish, required finish within budget");
      $fatal(1);
   end

   initial begin
      int nl;
      int px;
      cif.cmd_valid   = 1'b0;
      cif.cmd_pattern = 8'd0;
      repeat (2) @(negedge clk_in);
      chk("rst_pattern", 32'(pattern), 32'd5);
      chk("rst_ramp", 32'(ramp_step), 32'd0);
      chk("rst_pv", 32'(pv), 32'd0);
      chk("rst_ready", 32'(cif.cmd_ready), 32'd1);
      chk("rst_tap", 32'(tap), 32'd0);
      chk("rst_tal", 32'(tal), 32'd0);
      chk("rst_fs", 32'(fs), 32'd0);
      reset = 1'b0;
      @(negedge clk_in);

      repeat (4) frame(2, 1280, 0, -1);
      repeat (2) frame(2, 1920, 0, -1);
      frame(3, 1, 0, -1);
      frame(0, 0, 0, -1);
      frame(2, 7, 0, -1);

      frame(2, 10, 0, -1);
      frame(1, 3, 1, -1);
      frame(1, 3, 0, -1);

      send_cmd(2);
      send_cmd(4);
      frame(1, 5, 0, -1);
      frame(1, 5, 0, 7);
      frame(1, 5, 0, -1);

      send_cmd(3);
      auto_en = 1'b1;
      fpp = 8'd2;
      np = 8'd4;
      repeat (9) frame(1, 6, 0, -1);
      fpp = 8'd0;
      repeat (4) frame(1, 6, 0, -1);

      frame(1, 12, 0, -1);
      frame(2, 33, 0, -1);
      reset = 1'b1;
      @(negedge clk_in);
      chk("mid_rst_pattern", 32'(pattern), 32'd5);
      chk("mid_rst_ramp", 32'(ramp_step), 32'd0);
      chk("mid_rst_pv", 32'(pv), 32'd0);
      chk("mid_rst_ready", 32'(cif.cmd_ready), 32'd1);
      reset = 1'b0;
      model_reset();
      @(negedge clk_in);
      frame(2, 33, 0, -1);
      frame(1, 33, 0, -1);

      for (int f = 0; f < 40; f++) begin
         if ($urandom_range(0, 3) == 0) begin
            auto_en = 1'($urandom_range(0, 1));
            fpp = 8'($urandom_range(0, 3));
            np = 8'($urandom_range(0, 6));
         end
         if ($urandom_range(0, 2) == 0)
            send_cmd($urandom_range(0, 1) != 0 ?
                     int'($urandom_range(0, 7)) : int'($urandom_range(0, 255)));
         nl = int'($urandom_range(0, 5));
         px = ($urandom_range(0, 2) == 0) ? 0 : ((m_tpix > 0) ? m_tpix : 9);
         frame(nl, px, 0, ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 7)) : -1);
      end

      repeat (40) @(negedge clk_in);
      chk("frame_queue_drained", 32'(fq.size()), 32'd0);
      chk("ramp_queue_drained", 32'(rq.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
